// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline register with valid/ready handshake and
// a 2-entry skid buffer (main + skid). ex_ready comes straight from a flop
// (~skid_v), so MEM backpressure never reaches EX combinationally.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   flush             synchronous squash of all held entries
//   ex_valid/ex_ready EX-side handshake
//   ex_aluresult, ex_swdata, ex_writeaddr, ex_aluop, ex_ctrl  EX payload
//   mem_valid/mem_ready MEM-side handshake
//   mem_aluresult, mem_swdata, mem_writeaddr, mem_aluop  held payload
//   mem_ctrl          {memwrite,memread,regwrite,memtoreg}, gated by mem_valid
//   stall_cnt, bubble_cnt  saturating perf counters (only with EXMEM_PERF_EN)
//
// Optional feature macro: EXMEM_PERF_EN (adds the performance counters).
module ex_mem_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [DATA_W-1:0]  ex_aluresult,
  input  logic [DATA_W-1:0]  ex_swdata,
  input  logic [REG_AW-1:0]  ex_writeaddr,
  input  logic [ALUOP_W-1:0] ex_aluop,
  input  logic [3:0]         ex_ctrl,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [DATA_W-1:0]  mem_aluresult,
  output logic [DATA_W-1:0]  mem_swdata,
  output logic [REG_AW-1:0]  mem_writeaddr,
  output logic [ALUOP_W-1:0] mem_aluop,
  output logic [3:0]         mem_ctrl
`ifdef EXMEM_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0]  aluresult;
    logic [DATA_W-1:0]  swdata;
    logic [REG_AW-1:0]  writeaddr;
    logic [ALUOP_W-1:0] aluop;
    logic [3:0]         ctrl;
  } payload_t;

  payload_t in_p, main_p, skid_p;
  logic     main_v, skid_v;
  logic     in_xfer, out_xfer;

  assign in_p     = {ex_aluresult, ex_swdata, ex_writeaddr, ex_aluop, ex_ctrl};
  assign ex_ready = ~skid_v;
  assign in_xfer  = ex_valid & ~skid_v;
  assign out_xfer = main_v & mem_ready;

  // State {main_v,skid_v}: 00 EMPTY, 10 ONE, 11 FULL. The skid entry is
  // always older than anything new, so FULL refuses input until it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_p <= '0;
      skid_p <= '0;
    end else if (flush) begin
      // Payload is left alone; only validity is squashed.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case ({main_v, skid_v})
        2'b00: if (in_xfer) begin
          main_p <= in_p;
          main_v <= 1'b1;
        end
        2'b10: begin
          if (in_xfer && out_xfer) main_p <= in_p;
          else if (out_xfer)       main_v <= 1'b0;
          else if (in_xfer) begin
            skid_p <= in_p;
            skid_v <= 1'b1;
          end
        end
        2'b11: if (out_xfer) begin
          main_p <= skid_p;
          skid_v <= 1'b0;
        end
        default: begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid     = main_v;
  assign mem_aluresult = main_p.aluresult;
  assign mem_swdata    = main_p.swdata;
  assign mem_writeaddr = main_p.writeaddr;
  assign mem_aluop     = main_p.aluop;
  assign mem_ctrl      = main_p.ctrl & {4{main_v}};

`ifdef EXMEM_PERF_EN
  // Saturating counters; only reset clears them, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v && !mem_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (!main_v && !(&bubble_cnt))             bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
